// File: rtl/pixel_readout_pkg.sv
// Shared definitions for the pixel array readout: pixel width and FSM state encoding.
package pixel_readout_pkg;

  localparam int PIXEL_W = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  function automatic int idx_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/pixel_row_buffer.sv
// Holds one captured row of pixels and muxes out the pixel chosen by sel.
module pixel_row_buffer
  import pixel_readout_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  logic [WIDTH*PIXEL_W-1:0]            row_in,
  input  logic [idx_width(WIDTH)-1:0]         sel,
  output logic [PIXEL_W-1:0]                  data_out
);

  logic [PIXEL_W-1:0] buf_q [WIDTH];

  // Pixel 0 sits in the most significant byte of the row bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) buf_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WIDTH; i++) buf_q[i] <= row_in[(WIDTH-1-i)*PIXEL_W +: PIXEL_W];
    end
  end

  assign data_out = buf_q[sel];

endmodule

// File: rtl/pixel_readout.sv
// Row-by-row readout of a pixel array: select row, let it settle, capture, stream pixels.
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int PIXEL_ARRAY_WIDTH  = 2,
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int SETTLE_CYCLES      = 2
) (
  input  logic                                  CLK,
  input  logic                                  RESET_N,
  input  logic                                  START,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_W-1:0]  ROW_DATA,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]         READ_ROW,
  output logic [PIXEL_W-1:0]                    OUT_DATA,
  output logic                                  OUT_VALID,
  input  logic                                  OUT_READY,
  output logic                                  OUT_LAST,
  output logic                                  BUSY,
  output logic                                  DONE
);

  localparam int ROW_W = idx_width(PIXEL_ARRAY_HEIGHT);
  localparam int PIX_W = idx_width(PIXEL_ARRAY_WIDTH);
  localparam int SET_W = idx_width(SETTLE_CYCLES);

  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [PIX_W-1:0] LAST_PIX    = PIX_W'(PIXEL_ARRAY_WIDTH - 1);
  localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [PIXEL_W-1:0] buf_data;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      pix_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      pix_q    <= pix_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    pix_d    = pix_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_SELECT;
          row_d    = '0;
          settle_d = '0;
        end
      end
      S_SELECT: begin
        if (settle_q == LAST_SETTLE) state_d = S_CAPTURE;
        else                         settle_d = settle_q + 1'b1;
      end
      S_CAPTURE: begin
        state_d = S_STREAM;
        pix_d   = '0;
      end
      S_STREAM: begin
        if (OUT_READY) begin
          if (pix_q != LAST_PIX) begin
            pix_d = pix_q + 1'b1;
          end else if (row_q == LAST_ROW) begin
            state_d = S_FINISH;
          end else begin
            state_d  = S_SELECT;
            row_d    = row_q + 1'b1;
            settle_d = '0;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Row buffer is loaded on the edge that leaves CAPTURE, while READ is still driven.
  pixel_row_buffer #(
    .WIDTH (PIXEL_ARRAY_WIDTH)
  ) u_row_buffer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (state_q == S_CAPTURE),
    .row_in   (ROW_DATA),
    .sel      (pix_q),
    .data_out (buf_data)
  );

  always_comb begin
    READ_ROW = '0;
    if (state_q == S_SELECT || state_q == S_CAPTURE) READ_ROW[row_q] = 1'b1;
  end

  assign OUT_VALID = (state_q == S_STREAM);
  assign OUT_DATA  = OUT_VALID ? buf_data : '0;
  assign OUT_LAST  = OUT_VALID && (row_q == LAST_ROW) && (pix_q == LAST_PIX);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_FINISH);

endmodule
